// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: 8088 bus-cycle controller.
// Latches the address on ALE and decodes it into one-hot chip selects.
// Inserts per-region wait states on READY and pulses BUS_ERR on unmapped or malformed cycles.
// Optional feature: define BUS_CYCLE_CTRL_MULTI_HIT_CHK_EN to add a sticky MULTI_HIT flag
// that reports overlapping region hits.
module bus_cycle_ctrl #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned WAIT_W = 3,
  parameter logic [NUM_CS*ADDR_W-1:0] CS_BASE = {20'h0FF00, 20'h01C00, 20'h80000, 20'h00000},
  parameter logic [NUM_CS*ADDR_W-1:0] CS_MASK = {20'h0FFF0, 20'h0FE00, 20'h80000, 20'h80000},
  parameter logic [NUM_CS-1:0]        CS_IOM  = 4'b1100,
  parameter logic [NUM_CS*WAIT_W-1:0] CS_WAIT = {3'd3, 3'd0, 3'd2, 3'd1}
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] AD_IN,
  output logic [ADDR_W-1:0] Address,
  output logic [NUM_CS-1:0] CS,
  output logic              READY,
  output logic              BUS_ERR,
  output logic              CYCLE_ACTIVE
`ifdef BUS_CYCLE_CTRL_MULTI_HIT_CHK_EN
  ,
  output logic              MULTI_HIT
`endif
);

  typedef enum logic [1:0] {StIdle, StDecode, StWait, StActive} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   address_q;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  // Set when the current cycle was rejected, so CS stays low for the rest of it.
  logic                bad_q, bad_d;
  logic [NUM_CS-1:0]   hit_vec;
  logic [NUM_CS-1:0]   hit_oh;
  logic [WAIT_W-1:0]   wait_sel;
  logic                hit_any;
  logic                strobe;
  logic                both_strobes;
  logic                cs_en;
`ifdef BUS_CYCLE_CTRL_MULTI_HIT_CHK_EN
  logic                multi_q, multi_d;
`endif

  // Region compare, lowest-index priority and the winner's wait count.
  always_comb begin
    hit_vec  = '0;
    hit_oh   = '0;
    wait_sel = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      hit_vec[i] = ((address_q & CS_MASK[i*ADDR_W +: ADDR_W]) == CS_BASE[i*ADDR_W +: ADDR_W]) &&
                   (IOM == CS_IOM[i]);
    end
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CS; i++) begin
      if (hit_oh[i]) wait_sel = wait_sel | CS_WAIT[i*WAIT_W +: WAIT_W];
    end
  end

  assign hit_any      = |hit_vec;
  assign strobe       = !RD || !WR;
  assign both_strobes = !RD && !WR;

  // Next-state, wait counter, READY and error pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    bad_d   = bad_q;
`ifdef BUS_CYCLE_CTRL_MULTI_HIT_CHK_EN
    multi_d = multi_q;
`endif
    if (ALE) begin
      // A new address phase aborts whatever cycle was running.
      state_d = StDecode;
      ready_d = 1'b1;
      cnt_d   = '0;
      bad_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          bad_d = 1'b0;
        end
        StDecode: begin
          if (strobe) begin
            if (hit_any && !both_strobes) begin
`ifdef BUS_CYCLE_CTRL_MULTI_HIT_CHK_EN
              if ($countones(hit_vec) > 1) begin
                multi_d = 1'b1;
                err_d   = 1'b1;
              end
`endif
              if (wait_sel == '0) begin
                state_d = StActive;
              end else begin
                state_d = StWait;
                ready_d = 1'b0;
                cnt_d   = wait_sel - 1'b1;
              end
            end else begin
              // READY stays high so the processor cannot hang on a bad cycle.
              state_d = StActive;
              err_d   = 1'b1;
              bad_d   = 1'b1;
            end
          end
        end
        StWait: begin
          if (!strobe) begin
            state_d = StIdle;
            ready_d = 1'b1;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = StActive;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StActive: begin
          if (!strobe) begin
            state_d = StIdle;
            bad_d   = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counter, address latch and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      address_q <= '0;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
`ifdef BUS_CYCLE_CTRL_MULTI_HIT_CHK_EN
      multi_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      bad_q   <= bad_d;
      if (ALE) address_q <= AD_IN;
`ifdef BUS_CYCLE_CTRL_MULTI_HIT_CHK_EN
      multi_q <= multi_d;
`endif
    end
  end

  // Chip selects are live only inside a cycle that has not been rejected.
  always_comb begin
    cs_en = (state_q != StIdle) && !bad_q && !((state_q == StDecode) && both_strobes);
    CS    = cs_en ? hit_oh : '0;
  end

  assign Address      = address_q;
  assign READY        = ready_q;
  assign BUS_ERR      = err_q;
  assign CYCLE_ACTIVE = (state_q != StIdle);
`ifdef BUS_CYCLE_CTRL_MULTI_HIT_CHK_EN
  assign MULTI_HIT    = multi_q;
`endif

endmodule
